// File: rtl/fsm_moore.sv
// fsm_moore: four-state Moore machine stepping a Gray-coded position.
// Ports: clk, reset (async active-low), in[1:0] command, out[1:0] state.
//   in: 00 hold, 01 advance, 10 retreat, 11 home (S0).
//   out: S0=00, S1=01, S2=11, S3=10, taken straight from the state flops.

module fsm_moore (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] in,
    output logic [1:0] out
);

    // State codes equal the output codes, so out is a plain flop copy.
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b11,
        S3 = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CMD_HOLD    = 2'b00,
        CMD_ADVANCE = 2'b01,
        CMD_RETREAT = 2'b10,
        CMD_HOME    = 2'b11
    } cmd_t;

    state_t state_q;
    state_t state_d;
    cmd_t   cmd;

    assign cmd = cmd_t'(in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (cmd)
            CMD_HOLD: begin
                state_d = state_q;
            end
            CMD_ADVANCE: begin
                case (state_q)
                    S0:      state_d = S1;
                    S1:      state_d = S2;
                    S2:      state_d = S3;
                    S3:      state_d = S0;
                    default: state_d = S0;
                endcase
            end
            CMD_RETREAT: begin
                case (state_q)
                    S0:      state_d = S3;
                    S3:      state_d = S2;
                    S2:      state_d = S1;
                    S1:      state_d = S0;
                    default: state_d = S0;
                endcase
            end
            CMD_HOME: begin
                state_d = S0;
            end
            default: begin
                state_d = S0;
            end
        endcase
    end

    assign out = state_q;

endmodule

// File: tb/tb_fsm_moore.sv
// tb_fsm_moore: directed and random checks of fsm_moore.
// Reference tracks a ring position 0..3 and Gray-codes it for out.

module tb_fsm_moore;

    logic       clk;
    logic       reset;
    logic [1:0] in;
    logic [1:0] out;

    int total;
    int bad;
    int pos;

    fsm_moore dut (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] gray(input int p);
        logic [1:0] b;
        b = 2'(p);
        return b ^ (b >> 1);
    endfunction

    function automatic int model_next(input int p, input logic [1:0] c);
        case (c)
            2'b01:   return (p + 1) % 4;
            2'b10:   return (p + 3) % 4;
            2'b11:   return 0;
            default: return p;
        endcase
    endfunction

    task automatic check(input logic [1:0] want, input string tag);
        total++;
        assert (out === want)
        else begin
            bad++;
            $error("FAIL %s out=%b want=%b", tag, out, want);
        end
    endtask

    // Directed step: expected value written out by hand.
    task automatic step(input logic [1:0] c, input logic [1:0] want,
                        input string tag);
        in = c;
        @(posedge clk);
        #1;
        pos = model_next(pos, c);
        check(want, tag);
    endtask

    // Model-driven step.
    task automatic mstep(input logic [1:0] c, input string tag);
        in = c;
        @(posedge clk);
        #1;
        pos = model_next(pos, c);
        check(gray(pos), tag);
    endtask

    // Called 1 time unit after a rising edge: assert reset between
    // edges, hold it across one edge, release it between edges.
    task automatic mid_reset(input string tag);
        #3;
        reset = 1'b0;
        #1;
        pos = 0;
        check(2'b00, {tag, "_async"});
        in = 2'($urandom_range(3));
        @(posedge clk);
        #1;
        check(2'b00, {tag, "_held"});
        reset = 1'b1;
        #1;
        check(2'b00, {tag, "_release"});
    endtask

    initial begin
        logic [1:0] mix_in [9];
        logic [1:0] mix_out[9];
        total = 0;
        bad   = 0;
        pos   = 0;
        reset = 1'b0;
        in    = 2'b00;

        #1;
        check(2'b00, "reset_pre_edge");
        @(posedge clk);
        #1;
        check(2'b00, "reset_edge");
        in = 2'b01;
        @(posedge clk);
        #1;
        check(2'b00, "reset_ignores_in");
        reset = 1'b1;
        #1;
        check(2'b00, "release_no_change");

        step(2'b00, 2'b00, "first_hold");

        step(2'b01, 2'b01, "adv1");
        step(2'b01, 2'b11, "adv2");
        step(2'b01, 2'b10, "adv3");
        step(2'b01, 2'b00, "adv_wrap");

        step(2'b10, 2'b10, "ret_wrap");
        step(2'b10, 2'b11, "ret2");
        step(2'b11, 2'b00, "home");
        step(2'b11, 2'b00, "home_in_s0");

        mix_in  = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b10,
                    2'b11, 2'b00, 2'b11, 2'b10};
        mix_out = '{2'b01, 2'b11, 2'b00, 2'b00, 2'b10,
                    2'b00, 2'b00, 2'b00, 2'b10};
        step(2'b11, 2'b00, "mix_home");
        for (int i = 0; i < 9; i++) begin
            step(mix_in[i], mix_out[i], $sformatf("mix%0d", i));
        end

        step(2'b11, 2'b00, "pre_s2_home");
        step(2'b01, 2'b01, "to_s1");
        step(2'b01, 2'b11, "to_s2");
        mid_reset("mid_s2");
        step(2'b10, 2'b10, "post_reset_ret");

        for (int i = 0; i < 5; i++) begin
            step(2'b00, 2'b10, $sformatf("hold_s3_%0d", i));
        end

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(24) == 0) begin
                mid_reset($sformatf("rnd_rst%0d", i));
            end else begin
                mstep(2'($urandom_range(3)), $sformatf("rnd%0d", i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
